// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame geometry and line levels
// common to the trigger receiver and the buffered transmitter.
package uart_pkg;

    typedef enum logic {IDLE = 1'b0, XMIT = 1'b1} tx_state_t;

    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Builds an 8N1 frame, LSB transmitted first.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {STOP_BIT, data, START_BIT};
    endfunction

endpackage

// File: rtl/uart_trig_tx_if.sv
// Enqueue-side bus of the buffered UART transmitter: write strobe, data and FIFO status.
interface uart_trig_tx_if;

    logic [7:0] tx_data;
    logic       wr;
    logic       full;
    logic       empty;

    modport master (output tx_data, output wr, input full, input empty);
    modport slave  (input tx_data, input wr, output full, output empty);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with power-of-two depth; status flags are derived from registered
// pointers that carry one extra wrap bit.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // A write into a full FIFO is dropped even when a pop happens in the same cycle.
    assign wr_en_s = wr && !full;
    assign rd_en_s = rd && !empty;

    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty = (wptr_r == rptr_r);
    assign dout  = mem_r[rptr_r[AW-1:0]];

    // Storage array; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wptr_r[AW-1:0]] <= din;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (wr_en_s) begin
                wptr_r <= wptr_r + (AW+1)'(1);
            end
            if (rd_en_s) begin
                rptr_r <= rptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_trig_tx.sv
// Buffered 8N1 UART transmitter: FIFO-fed frame serializer with a run-time bit period
// that is latched per frame; consecutive frames are sent without idle gaps.
module uart_trig_tx
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          baud_cnt,
    uart_trig_tx_if.slave        bus,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done
);

    tx_state_t             state_r;
    tx_state_t             state_nxt_s;
    logic [15:0]           baud_ctr_r;
    logic [15:0]           baud_lat_r;
    logic [3:0]            bit_ctr_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic                  tx_done_r;
    logic [7:0]            fifo_dout_s;
    logic                  pop_s;
    logic                  bit_end_s;
    logic                  frame_end_s;

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (bus.wr),
        .rd    (pop_s),
        .din   (bus.tx_data),
        .dout  (fifo_dout_s),
        .full  (bus.full),
        .empty (bus.empty)
    );

    // Next-state and pop decision; the next byte is loaded on the last stop-bit edge.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        frame_end_s = 1'b0;
        bit_end_s   = (baud_ctr_r == baud_lat_r);
        case (state_r)
            IDLE: begin
                if (!bus.empty) begin
                    pop_s       = 1'b1;
                    state_nxt_s = XMIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XMIT: begin
                if (bit_end_s && (bit_ctr_r == 4'(FRAME_BITS - 1))) begin
                    frame_end_s = 1'b1;
                    if (!bus.empty) begin
                        pop_s       = 1'b1;
                        state_nxt_s = XMIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = XMIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Serializer datapath; the shift register idles at all-ones so TX rests high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_ctr_r <= 16'd0;
            baud_lat_r <= 16'd0;
            bit_ctr_r  <= 4'd0;
            shift_r    <= {FRAME_BITS{STOP_BIT}};
            tx_done_r  <= 1'b0;
        end else begin
            tx_done_r <= frame_end_s;
            if (pop_s) begin
                shift_r    <= make_frame(fifo_dout_s);
                baud_ctr_r <= 16'd0;
                bit_ctr_r  <= 4'd0;
                baud_lat_r <= baud_cnt;
            end else if (state_r == XMIT) begin
                if (bit_end_s) begin
                    baud_ctr_r <= 16'd0;
                    shift_r    <= {STOP_BIT, shift_r[FRAME_BITS-1:1]};
                    bit_ctr_r  <= bit_ctr_r + 4'd1;
                end else begin
                    baud_ctr_r <= baud_ctr_r + 16'd1;
                end
            end
        end
    end

    assign TX      = shift_r[0];
    assign tx_busy = (state_r == XMIT);
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_trig_tx.sv
// Scoreboard bench for uart_trig_tx: stimulus queues expected frames, a negedge monitor
// decodes TX bit by bit and checks frame timing, tx_done and gapless back-to-back frames.
module tb_uart_trig_tx;
    import uart_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_cnt;
    logic        TX;
    logic        tx_busy;
    logic        tx_done;

    uart_trig_tx_if bus ();

    uart_trig_tx #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_cnt (baud_cnt),
        .bus      (bus),
        .TX       (TX),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         baud;
        bit         gapless;
        bit         chk_empty;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_active = 1'b0;
    bit   pend_done = 1'b0;
    int   cyc = 0;
    exp_t cur;

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic checkn(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int b, input bit g, input bit e);
        exp_t x;
        x.data      = d;
        x.baud      = b;
        x.gapless   = g;
        x.chk_empty = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while ((tx_busy || !bus.empty) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check1({name, "_idle_timeout"}, (n < 3000), 1'b1);
        repeat (3) @(negedge clk);
        checkn({name, "_frames_pending"}, exp_q.size(), 0);
    endtask

    // Monitor: decodes each frame on TX and checks levels, duration and tx_done.
    always @(negedge clk) begin
        logic [9:0] frame_v;
        int         bit_i;
        if (!rst_n) begin
            mon_active = 1'b0;
            pend_done  = 1'b0;
            cyc        = 0;
        end else begin
            if (pend_done) begin
                check1("tx_done_pulse", tx_done, 1'b1);
                pend_done = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].gapless) begin
                    check1("no_gap_start", TX, 1'b0);
                end
            end else begin
                check1("tx_done_quiet", tx_done, 1'b0);
            end
            if (!mon_active && TX == 1'b0) begin
                check1("frame_expected", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0) begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    cyc        = 0;
                    if (cur.chk_empty) begin
                        check1("empty_after_pop", bus.empty, 1'b1);
                    end
                end
            end
            if (mon_active) begin
                frame_v = {1'b1, cur.data, 1'b0};
                bit_i   = cyc / (cur.baud + 1);
                check1($sformatf("tx_bit%0d_of_%02h", bit_i, cur.data), TX, frame_v[bit_i]);
                cyc++;
                if (cyc == 10 * (cur.baud + 1)) begin
                    mon_active = 1'b0;
                    pend_done  = 1'b1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        baud_cnt    = 16'd15;
        bus.wr      = 1'b0;
        bus.tx_data = 8'h00;

        repeat (3) @(negedge clk);
        check1("rst_tx", TX, 1'b1);
        check1("rst_full", bus.full, 1'b0);
        check1("rst_empty", bus.empty, 1'b1);
        check1("rst_busy", tx_busy, 1'b0);
        check1("rst_done", tx_done, 1'b0);
        rst_n = 1'b1;

        // Single byte 0xA5 at 16 cycles per bit, with pop latency checks.
        @(negedge clk);
        bus.wr = 1'b1; bus.tx_data = 8'hA5; push_exp(8'hA5, 15, 1'b0, 1'b1);
        @(negedge clk);
        bus.wr = 1'b0;
        check1("lat_tx_after_e0", TX, 1'b1);
        check1("lat_empty_after_e0", bus.empty, 1'b0);
        check1("lat_busy_after_e0", tx_busy, 1'b0);
        @(negedge clk);
        check1("lat_tx_after_e1", TX, 1'b0);
        check1("lat_busy_after_e1", tx_busy, 1'b1);
        wait_idle("single");

        // Back-to-back frames at 4 cycles per bit.
        baud_cnt = 16'd3;
        @(negedge clk);
        bus.wr = 1'b1; bus.tx_data = 8'h01; push_exp(8'h01, 3, 1'b0, 1'b0);
        @(negedge clk);
        bus.tx_data = 8'h02; push_exp(8'h02, 3, 1'b1, 1'b0);
        @(negedge clk);
        bus.tx_data = 8'h03; push_exp(8'h03, 3, 1'b1, 1'b1);
        @(negedge clk);
        bus.wr = 1'b0;
        wait_idle("b2b");

        // Overflow: six writes, the sixth lands while full and is dropped.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.wr = 1'b1; bus.tx_data = 8'h10 + 8'(i);
            if (i == 5) begin
                check1("ovf_full_at_6th", bus.full, 1'b1);
            end else begin
                push_exp(8'h10 + 8'(i), 3, (i != 0), (i == 4));
            end
        end
        @(negedge clk);
        bus.wr = 1'b0;
        check1("ovf_full_after_drop", bus.full, 1'b1);
        wait_idle("overflow");

        // One-cycle bits.
        baud_cnt = 16'd0;
        @(negedge clk);
        bus.wr = 1'b1; bus.tx_data = 8'hC3; push_exp(8'hC3, 0, 1'b0, 1'b0);
        @(negedge clk);
        bus.tx_data = 8'h81; push_exp(8'h81, 0, 1'b1, 1'b1);
        @(negedge clk);
        bus.wr = 1'b0;
        wait_idle("baud0");

        // Bit period change mid-frame applies only from the next frame.
        baud_cnt = 16'd7;
        @(negedge clk);
        bus.wr = 1'b1; bus.tx_data = 8'h5A; push_exp(8'h5A, 7, 1'b0, 1'b1);
        @(negedge clk);
        bus.wr = 1'b0;
        repeat (20) @(negedge clk);
        baud_cnt = 16'd3;
        bus.wr = 1'b1; bus.tx_data = 8'h3C; push_exp(8'h3C, 3, 1'b1, 1'b1);
        @(negedge clk);
        bus.wr = 1'b0;
        wait_idle("baud_change");

        // Reset during bit 4 with two bytes still queued.
        baud_cnt = 16'd15;
        @(negedge clk);
        bus.wr = 1'b1; bus.tx_data = 8'h77; push_exp(8'h77, 15, 1'b0, 1'b0);
        @(negedge clk);
        bus.tx_data = 8'h88; push_exp(8'h88, 15, 1'b1, 1'b0);
        @(negedge clk);
        bus.tx_data = 8'h99; push_exp(8'h99, 15, 1'b1, 1'b1);
        @(negedge clk);
        bus.wr = 1'b0;
        repeat (70) @(negedge clk);
        check1("pre_rst_busy", tx_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("midrst_tx", TX, 1'b1);
        check1("midrst_empty", bus.empty, 1'b1);
        check1("midrst_busy", tx_busy, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check1("post_rst_tx_idle", TX, 1'b1);
        check1("post_rst_busy", tx_busy, 1'b0);
        check1("post_rst_empty", bus.empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_trig_tx.md
# uart_trig_tx

Buffered UART transmitter, the transmit-side counterpart of the UART trigger receiver. It is used to drive serial stimulus and protocol traffic from the analyzer core onto a TX pin. Bytes are pushed into a small internal FIFO and serialized as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). The bit period is set by the same run-time `baud_cnt` register the receiver uses, so the two ends are rate-compatible.

## Interface
- `DEPTH`, default 4, is the FIFO depth in bytes. It must be a power of 2 and at least 2.
- `clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `baud_cnt`, input, 16 bits: bit period minus one, in clk cycles.
- `tx_data`, input, 8 bits: byte to enqueue.
- `wr`, input, 1 bit: enqueue strobe. Sampled every edge.
- `TX`, output, 1 bit: serial line. Registered; idles high.
- `full`, output, 1 bit: FIFO holds DEPTH bytes.
- `empty`, output, 1 bit: FIFO holds 0 bytes.
- `tx_busy`, output, 1 bit: a frame is in progress (state XMIT).
- `tx_done`, output, 1 bit: one-cycle pulse at the end of each stop bit.

## Operation
- **Reset values:** TX=1, full=0, empty=1, tx_busy=0, tx_done=0. FIFO pointers are cleared, state is IDLE, and the bit and baud counters are 0.
- **Enqueue:**
  - If `wr` is high and `full` is low at an edge, `tx_data` is written and the count increments.
  - If `wr` is high while `full` is high, the write is dropped silently. This holds even if a pop occurs in the same cycle.
- **Pop:** In IDLE with `!empty`, the head byte is popped and loaded into a 10-bit shift register as {1, data, 0}. The baud counter is cleared, the bit counter is cleared, `baud_cnt` is latched into a frame-local register, and the state goes to XMIT.
- **XMIT:**
  - TX is the shift register LSB.
  - The baud counter increments each cycle.
  - When it equals the latched `baud_cnt`, it clears, the shift register shifts right (filling with 1), and the bit counter increments.
- **End of frame:** When the bit counter reaches 10, `tx_done` pulses for one cycle.
  - If the FIFO is non-empty, the next byte is popped and loaded in that same cycle and the state stays XMIT. There is no idle gap between frames.
  - If the FIFO is empty, the state goes to IDLE and TX stays 1.
- **Width rules:** The bit counter is 4 bits and the baud counter is 16 bits. `baud_cnt`=0 gives a 1-cycle bit. `baud_cnt`=16'hFFFF gives a 65536-cycle bit and must not overflow.
- **Simultaneous push and pop:** When not full, both take effect and the count is unchanged.
- **Reset mid-frame:** TX returns to 1 immediately (asynchronously) and the FIFO contents are discarded.

## Timing
- Each bit is `baud_cnt`+1 cycles. A frame is 10*(`baud_cnt`+1) cycles.
- Latency from an idle, empty FIFO:
  - `wr` is sampled at edge E0, and `empty` falls after E0.
  - The pop happens at E1. TX falls and `tx_busy` rises after E1.
- `tx_done` is high in the cycle after the last stop-bit cycle. `tx_busy` falls in that same cycle if the FIFO is empty.
- A change to `baud_cnt` during a frame takes effect at the next frame load.
- `full` and `empty` are registered, or derived from registered pointers. They are valid the cycle after the edge that changes them.

## Structure
- The package `uart_pkg` holds:
  - `typedef enum logic {IDLE, XMIT} tx_state_t`
  - `localparam FRAME_BITS = 10`
  - start and stop bit level constants, shared with the receiver.
- Sub-module `uart_fifo #(DEPTH, WIDTH=8)` provides the synchronous FIFO with `full`/`empty`, plus `wr`/`rd` and `din`/`dout`.
- The top level contains the FSM, the baud counter, the bit counter and the shift register.

## Test plan
- **Single byte:** `baud_cnt`=15, write 0xA5. Expect TX to read 0, then 1,0,1,0,0,1,0,1, then 1, each level held 16 cycles. TX falls 2 edges after `wr`. `tx_done` pulses once, 160 cycles after TX falls.
- **Back-to-back:** write 0x01, 0x02, 0x03 on consecutive cycles with `baud_cnt`=3. Expect 3 frames of 40 cycles each with no idle gap, 3 `tx_done` pulses, and `empty`=1 after the first pop of 0x03.
- **Overflow:** DEPTH=4, write 0x10 through 0x15 on 6 consecutive cycles. Expect 5 bytes transmitted (0x10 through 0x14), with 0x15 dropped because `full` was high at the 6th edge.
- **Loopback:** connect TX to the UART trigger receiver with matching `baud_cnt`=31, match=0x45, mask=0x00, and send 0x45 then 0x44. Expect the trigger to fire exactly once.
- **Reset mid-frame:** assert `rst_n`=0 at bit 4 of a frame while 2 bytes are queued. Expect TX=1, `empty`=1, `tx_busy`=0 immediately. After reset release, no frame is sent.
- **baud_cnt change:** change `baud_cnt` from 7 to 3 mid-frame. Expect the current frame to stay at 8 cycles/bit and the next frame to run at 4 cycles/bit.
